// File: rtl/time_set_ctrl.sv
// Front-panel time-setting sequencer: RUN/EDIT mode, field select, inc/dec strobes
// with auto-repeat, edit timeout and blink mask for the selected field.
module time_set_ctrl #(
    parameter int unsigned NUM_FIELDS = 4,
    parameter int unsigned REP_DELAY  = 500,
    parameter int unsigned REP_RATE   = 100,
    parameter int unsigned TIMEOUT    = 10000,
    parameter int unsigned BLINK_HALF = 250
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick,
    input  logic       i_mode_pulse,
    input  logic       i_next_pulse,
    input  logic       i_prev_pulse,
    input  logic       i_up_lvl,
    input  logic       i_down_lvl,
    output logic       o_run,
    output logic [1:0] o_field,
    output logic [3:0] o_inc_ena,
    output logic [3:0] o_dec_ena,
    output logic [3:0] o_blank,
    output logic       o_sec_clr
);

    localparam int unsigned CW = 14;
    localparam int unsigned FW = 4;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_EDIT   = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_REPEAT = 2'd3;

    localparam logic [CW-1:0] DELAY_C   = CW'(REP_DELAY);
    localparam logic [CW-1:0] RATE_C    = CW'(REP_RATE);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] BLINK_C   = CW'(BLINK_HALF);
    localparam logic [1:0]    LAST_FLD  = 2'(NUM_FIELDS - 1);

    logic          mode_q, next_q, prev_q, up_q, down_q, tick_q, up_d, down_d;
    logic [1:0]    state, state_nxt;
    logic          held_up, held_up_nxt;
    logic [CW-1:0] rep_cnt, rep_nxt, to_cnt, to_nxt, blink_cnt, blink_nxt;
    logic          phase, phase_nxt;
    logic [1:0]    field_nxt;
    logic          strobe, strobe_up, blink_clr, sec_clr_nxt;
    logic [FW-1:0] inc_nxt, dec_nxt, blank_nxt;
    logic [CW-1:0] rep_lim;
    logic          up_rise, down_rise, held_lvl, other_lvl, activity;

    assign up_rise   = up_q & ~up_d;
    assign down_rise = down_q & ~down_d;
    assign held_lvl  = held_up ? up_q : down_q;
    assign other_lvl = held_up ? down_q : up_q;
    assign activity  = mode_q | next_q | prev_q | up_rise | down_rise | up_q | down_q;
    assign rep_lim   = (state == S_HOLD) ? DELAY_C : RATE_C;

    // Next-state, counters and next output values
    always_comb begin
        state_nxt   = state;
        held_up_nxt = held_up;
        rep_nxt     = rep_cnt;
        to_nxt      = to_cnt;
        blink_nxt   = blink_cnt;
        phase_nxt   = phase;
        field_nxt   = o_field;
        strobe      = 1'b0;
        strobe_up   = 1'b0;
        blink_clr   = 1'b0;
        sec_clr_nxt = 1'b0;
        inc_nxt     = '0;
        dec_nxt     = '0;
        blank_nxt   = '0;

        case (state)
            S_RUN: begin
                if (mode_q) begin
                    state_nxt = S_EDIT;
                    field_nxt = 2'd0;
                    to_nxt    = '0;
                    blink_clr = 1'b1;
                end
            end
            default: begin
                if (mode_q) begin
                    state_nxt   = S_RUN;
                    sec_clr_nxt = 1'b1;
                end else begin
                    if (next_q ^ prev_q) begin
                        state_nxt = S_EDIT;
                        blink_clr = 1'b1;
                        if (next_q) begin
                            field_nxt = (o_field == LAST_FLD) ? 2'd0 : o_field + 2'd1;
                        end else begin
                            field_nxt = (o_field == 2'd0) ? LAST_FLD : o_field - 2'd1;
                        end
                    end else if (state != S_EDIT) begin
                        if (!held_lvl || other_lvl) begin
                            state_nxt = S_EDIT;
                        end else if (tick_q) begin
                            if (rep_cnt + CW'(1) == rep_lim) begin
                                strobe    = 1'b1;
                                strobe_up = held_up;
                                rep_nxt   = '0;
                                state_nxt = S_REPEAT;
                            end else begin
                                rep_nxt = rep_cnt + CW'(1);
                            end
                        end
                    end else if (up_rise ^ down_rise) begin
                        strobe      = 1'b1;
                        strobe_up   = up_rise;
                        held_up_nxt = up_rise;
                        rep_nxt     = '0;
                        state_nxt   = S_HOLD;
                    end

                    // Inactivity timeout back to RUN
                    if (activity) begin
                        to_nxt = '0;
                    end else if (tick_q) begin
                        if (to_cnt + CW'(1) == TIMEOUT_C) begin
                            state_nxt   = S_RUN;
                            sec_clr_nxt = 1'b1;
                            to_nxt      = '0;
                        end else begin
                            to_nxt = to_cnt + CW'(1);
                        end
                    end

                    if (strobe) begin
                        blink_clr = 1'b1;
                    end
                end
            end
        endcase

        // Blink phase restarts visible on entry, field change and every strobe
        if (blink_clr) begin
            blink_nxt = '0;
            phase_nxt = 1'b0;
        end else if (tick_q && state != S_RUN) begin
            if (blink_cnt + CW'(1) == BLINK_C) begin
                blink_nxt = '0;
                phase_nxt = ~phase;
            end else begin
                blink_nxt = blink_cnt + CW'(1);
            end
        end

        if (strobe && strobe_up) begin
            inc_nxt = FW'(1) << o_field;
        end
        if (strobe && !strobe_up) begin
            dec_nxt = FW'(1) << o_field;
        end
        if (state_nxt != S_RUN && phase_nxt) begin
            blank_nxt = FW'(1) << field_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q    <= 1'b0;
            next_q    <= 1'b0;
            prev_q    <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            tick_q    <= 1'b0;
            up_d      <= 1'b0;
            down_d    <= 1'b0;
            state     <= S_RUN;
            held_up   <= 1'b0;
            rep_cnt   <= '0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            o_run     <= 1'b1;
            o_field   <= 2'd0;
            o_inc_ena <= '0;
            o_dec_ena <= '0;
            o_blank   <= '0;
            o_sec_clr <= 1'b0;
        end else begin
            mode_q    <= i_mode_pulse;
            next_q    <= i_next_pulse;
            prev_q    <= i_prev_pulse;
            up_q      <= i_up_lvl;
            down_q    <= i_down_lvl;
            tick_q    <= i_tick;
            up_d      <= up_q;
            down_d    <= down_q;
            state     <= state_nxt;
            held_up   <= held_up_nxt;
            rep_cnt   <= rep_nxt;
            to_cnt    <= to_nxt;
            blink_cnt <= blink_nxt;
            phase     <= phase_nxt;
            o_run     <= (state_nxt == S_RUN);
            o_field   <= field_nxt;
            o_inc_ena <= inc_nxt;
            o_dec_ena <= dec_nxt;
            o_blank   <= blank_nxt;
            o_sec_clr <= sec_clr_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed spec scenarios plus random button traffic,
// checked every cycle against a tick-counting behavioural model.
module tb_time_set_ctrl;

    localparam int NF = 4;
    localparam int RD = 4;
    localparam int RR = 2;
    localparam int TO = 8;
    localparam int BH = 2;

    typedef struct {
        logic       run;
        logic [1:0] field;
        logic [3:0] inc;
        logic [3:0] dec;
        logic [3:0] blank;
        logic       sc;
        logic [1:0] field3;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       mode, nxt, prv, up, dn, tick;
    logic       run, sec_clr;
    logic [1:0] field;
    logic [3:0] inc, dec, blank;
    logic       run3, sec_clr3;
    logic [1:0] field3;
    logic [3:0] inc3, dec3, blank3;

    time_set_ctrl #(.NUM_FIELDS(NF), .REP_DELAY(RD), .REP_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_mode_pulse(mode),
        .i_next_pulse(nxt), .i_prev_pulse(prv), .i_up_lvl(up), .i_down_lvl(dn),
        .o_run(run), .o_field(field), .o_inc_ena(inc), .o_dec_ena(dec),
        .o_blank(blank), .o_sec_clr(sec_clr)
    );

    time_set_ctrl #(.NUM_FIELDS(3), .REP_DELAY(RD), .REP_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_mode_pulse(mode),
        .i_next_pulse(nxt), .i_prev_pulse(prv), .i_up_lvl(up), .i_down_lvl(dn),
        .o_run(run3), .o_field(field3), .o_inc_ena(inc3), .o_dec_ena(dec3),
        .o_blank(blank3), .o_sec_clr(sec_clr3)
    );

    int vectors = 0;
    int miscompares = 0;
    int strobes_seen = 0;
    int sec_clr_seen = 0;

    // Model state: edit flag, held direction (+1 up, -1 down, 0 none), tick counters
    bit   m_edit, m_rep, m_phase, m_pu, m_pd;
    int   m_held, m_field, m_field3, m_blink, m_idle, m_hold;
    exp_t e1, e2;

    function automatic exp_t reset_exp();
        exp_t e;
        e.run = 1'b1; e.field = 2'd0; e.inc = '0; e.dec = '0;
        e.blank = '0; e.sc = 1'b0; e.field3 = 2'd0;
        return e;
    endfunction

    task automatic model_reset();
        m_edit = 0; m_rep = 0; m_phase = 0; m_pu = 0; m_pd = 0;
        m_held = 0; m_field = 0; m_field3 = 0; m_blink = 0; m_idle = 0; m_hold = 0;
        e1 = reset_exp();
        e2 = reset_exp();
    endtask

    task automatic model_step(input bit m, input bit n, input bit p, input bit u,
                              input bit d, input bit t, output exp_t e);
        bit ur, dr, strobe, s_up, clr, was_edit, mine, other;
        ur = u && !m_pu;
        dr = d && !m_pd;
        m_pu = u;
        m_pd = d;
        strobe = 0; s_up = 0; clr = 0;
        e.inc = '0; e.dec = '0; e.sc = 1'b0;
        was_edit = m_edit;
        if (!m_edit) begin
            if (m) begin
                m_edit = 1; m_held = 0; m_field = 0; m_field3 = 0; m_idle = 0; clr = 1;
            end
        end else if (m) begin
            m_edit = 0;
            e.sc = 1'b1;
        end else begin
            if (n != p) begin
                m_field  = n ? (m_field + 1) % NF : (m_field + NF - 1) % NF;
                m_field3 = n ? (m_field3 + 1) % 3 : (m_field3 + 2) % 3;
                m_held = 0;
                clr = 1;
            end else if (m_held != 0) begin
                mine  = (m_held > 0) ? u : d;
                other = (m_held > 0) ? d : u;
                if (!mine || other) begin
                    m_held = 0;
                end else if (t) begin
                    m_hold++;
                    if (m_hold == (m_rep ? RR : RD)) begin
                        strobe = 1; s_up = (m_held > 0); m_hold = 0; m_rep = 1;
                    end
                end
            end else if (ur != dr) begin
                strobe = 1; s_up = ur; m_held = ur ? 1 : -1; m_rep = 0; m_hold = 0;
            end
            if (n || p || u || d) begin
                m_idle = 0;
            end else if (t) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_edit = 0;
                    e.sc = 1'b1;
                end
            end
        end
        if (strobe) begin
            clr = 1;
            if (s_up) e.inc = 4'(1 << m_field);
            else      e.dec = 4'(1 << m_field);
        end
        if (clr) begin
            m_phase = 0;
            m_blink = 0;
        end else if (was_edit && t) begin
            m_blink++;
            if (m_blink == BH) begin
                m_phase = !m_phase;
                m_blink = 0;
            end
        end
        e.run    = !m_edit;
        e.field  = 2'(m_field);
        e.field3 = 2'(m_field3);
        e.blank  = (m_edit && m_phase) ? 4'(1 << m_field) : 4'd0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("run", 16'(run), 16'(e.run));
        chk("field", 16'(field), 16'(e.field));
        chk("inc_ena", 16'(inc), 16'(e.inc));
        chk("dec_ena", 16'(dec), 16'(e.dec));
        chk("blank", 16'(blank), 16'(e.blank));
        chk("sec_clr", 16'(sec_clr), 16'(e.sc));
        chk("field_nf3", 16'(field3), 16'(e.field3));
        if (inc != 4'd0 || dec != 4'd0) strobes_seen++;
        if (sec_clr) sec_clr_seen++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_run"}, 16'(run), 16'd1);
        chk({tag, "_field"}, 16'(field), 16'd0);
        chk({tag, "_inc"}, 16'(inc), 16'd0);
        chk({tag, "_dec"}, 16'(dec), 16'd0);
        chk({tag, "_blank"}, 16'(blank), 16'd0);
        chk({tag, "_sec_clr"}, 16'(sec_clr), 16'd0);
    endtask

    // One clock: check outputs due from two cycles back, then apply new inputs
    task automatic step(input bit m, input bit n, input bit p, input bit u, input bit d, input bit t);
        @(negedge clk);
        check_out(e2);
        e2 = e1;
        mode = m; nxt = n; prv = p; up = u; dn = d; tick = t;
        model_step(m, n, p, u, d, t, e1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(0, 0, 0, 0, 0, 0);
    endtask

    int pseq[5]  = '{3, 2, 1, 0, 3};
    int p3seq[5] = '{2, 1, 0, 2, 1};
    int n3seq[3] = '{1, 2, 0};
    bit cur_u, cur_d;

    initial begin
        rst_n = 1'b0;
        mode = 0; nxt = 0; prv = 0; up = 0; dn = 0; tick = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        idle(2);

        // Enter EDIT
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        chk("mode_enters_edit", 16'(run), 16'd0);
        chk("edit_field0", 16'(field), 16'd0);
        chk("edit_no_inc", 16'(inc), 16'd0);

        // prev wraps downward on both field counts
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 0);
            idle(2);
            chk("prev_seq", 16'(field), 16'(pseq[i]));
            chk("prev_seq_nf3", 16'(field3), 16'(p3seq[i]));
        end

        // Re-enter, next wraps with three fields
        step(1, 0, 0, 0, 0, 0); idle(2);
        step(1, 0, 0, 0, 0, 0); idle(2);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(2);
            chk("next_seq_nf3", 16'(field3), 16'(n3seq[i]));
        end

        // Auto-repeat on field 1
        step(1, 0, 0, 0, 0, 0); idle(2);
        step(1, 0, 0, 0, 0, 0); idle(2);
        step(0, 1, 0, 0, 0, 0); idle(2);
        strobes_seen = 0;
        step(0, 0, 0, 1, 0, 0);
        repeat (10) step(0, 0, 0, 1, 0, 1);
        idle(5);
        chk("repeat_strobe_count", 16'(strobes_seen), 16'd5);

        // up and down rising together
        strobes_seen = 0;
        step(0, 0, 0, 1, 1, 0);
        repeat (6) step(0, 0, 0, 1, 1, 1);
        idle(4);
        chk("updown_no_strobe", 16'(strobes_seen), 16'd0);

        // next+prev together, then mode+next together
        step(0, 1, 1, 0, 0, 0); idle(2);
        chk("nextprev_hold_field", 16'(field), 16'd1);
        step(1, 1, 0, 0, 0, 0); idle(2);
        chk("modenext_run", 16'(run), 16'd1);
        chk("modenext_field", 16'(field), 16'd1);

        // Idle timeout with blinking
        step(1, 0, 0, 0, 0, 0);
        sec_clr_seen = 0;
        repeat (14) step(0, 0, 0, 0, 0, 1);
        idle(2);
        chk("timeout_run", 16'(run), 16'd1);
        chk("timeout_sec_clr_once", 16'(sec_clr_seen), 16'd1);

        // Async reset in REPEAT
        step(1, 0, 0, 0, 0, 0); idle(2);
        step(0, 0, 0, 1, 0, 0);
        repeat (7) step(0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        tick = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        strobes_seen = 0;
        repeat (8) step(0, 0, 0, 1, 0, 1);
        idle(3);
        chk("post_reset_no_strobe", 16'(strobes_seen), 16'd0);

        // Random button traffic
        cur_u = 0;
        cur_d = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) cur_u = !cur_u;
            if ($urandom_range(9) == 0) cur_d = !cur_d;
            step($urandom_range(39) == 0, $urandom_range(11) == 0, $urandom_range(11) == 0,
                 cur_u, cur_d, $urandom_range(1) == 1);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
